systolic_skew_buffer: RTL
=========================

# systolic_skew_buffer

Parametrised input/output skew stage for the systolic array. It delays lane k of a LANES-wide word by k cycles (skew mode, array input side) or by LANES-1-k cycles (deskew mode, array output side). Per-lane valid bits travel with the data. A burst controller with valid/ready and last flags injects bubbles and drains the pipeline automatically after the final word. It replaces the fixed 10-lane, enable-only skew register.

## Interface

**Parameters**
- DATA_WIDTH, 8, bits per lane.
- LANES, 10, lane count. Must be ≥ 2; elaboration error otherwise.

**Ports**
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- clr_i  in  1  synchronous clear; same effect as reset; highest synchronous priority.
- mode_i  in  1  0 = skew, 1 = deskew; sampled only on the first accept from IDLE.
- valid_i  in  1  word_i/last_i valid.
- last_i  in  1  final word of the burst.
- ready_o  out  1  block accepts a word this cycle.
- word_i  in  LANES*DATA_WIDTH  lane k = bits [k*DATA_WIDTH +: DATA_WIDTH].
- skew_o  out  LANES*DATA_WIDTH  delayed lanes, same lane packing.
- lane_valid_o  out  LANES  per-lane valid, aligned with skew_o.
- busy_o  out  1  state != IDLE.
- done_o  out  1  one-cycle pulse when the last word's longest-delayed lane is on skew_o.

## Operation

- **accept** = valid_i && ready_o. ready_o = (state != DRAIN).
- **Injection:** each cycle the pipeline injects accept ? word_i : 0, with valid bit = accept. A non-accepting cycle is a zero bubble with valid 0.
- **Shifting:** all delay lines shift every cycle regardless of accept. Bubbles preserve inter-word timing.
- **Delay per lane:** lane k delay d_k = k (skew) or LANES-1-k (deskew).
  - d_k = 0: combinational pass-through of the injected value and valid.
  - d_k > 0: taken from register stage d_k of that lane's delay line.
  - Each lane has a LANES-1 stage line with a mode-selected tap.
- **Effective mode** = (state == IDLE) ? mode_i : mode_q. mode_q loads mode_i on an accept in IDLE. mode_i changes outside IDLE are ignored.
- **FSM states:** IDLE, STREAM, DRAIN. Down-counter cnt is width clog2(LANES).
  - IDLE: accept && !last_i → STREAM. accept && last_i → DRAIN with cnt ← LANES-1.
  - STREAM: accept && last_i → DRAIN with cnt ← LANES-1. Otherwise stay; non-accept cycles are bubbles.
  - DRAIN: ready_o=0, bubbles injected, cnt decrements each cycle. done_o = (state==DRAIN && cnt==1). At cnt==1 → IDLE.
- On return to IDLE all delay stages hold zero/invalid, so a mode change between bursts is glitch-free.
- **clr_i / rst_ni:** every delay stage and valid bit ← 0, mode_q ← 0, cnt ← 0, state ← IDLE.
  - Reset and clear apply mid-stream or mid-drain; in-flight data is discarded and no done_o is produced.
- No arithmetic on data; values pass bit-exact.

## Timing

- **Reset values:**
  - ready_o=1, busy_o=0, done_o=0.
  - lane_valid_o=0 and all registered lanes of skew_o = 0.
  - The zero-delay lane reflects word_i only when accept; valid_i must be low during reset.
- **Latency:** a word accepted at cycle T appears on lane k at cycle T+d_k.
- **Drain:** with last accepted at T:
  - ready_o=0 and busy_o=1 during cycles T+1 … T+LANES-1.
  - done_o=1 at cycle T+LANES-1 only.
  - IDLE, ready_o=1 and busy_o=0 at cycle T+LANES.
- **Throughput:** one word per cycle in STREAM. The next burst may start at T+LANES, giving LANES-1 dead cycles per burst.
- valid_i asserted during DRAIN is not accepted; the source holds it until ready_o=1.

## Test plan

All scenarios use LANES=4, DATA_WIDTH=8.

- **Skew burst:** mode_i=0; W0=0x04030201 at cycle 0, W1=0x14131211 with last_i at cycle 1.
  - Lane k shows byte k+1 at cycle k and 0x11+k at cycle k+1; lane_valid_o matches.
  - ready_o=0 cycles 2–4; done_o at cycle 4 only; busy_o=0 at cycle 5.
- **Deskew burst:** mode_i=1, same stimulus.
  - Lane 3 shows 0x04/0x14 at cycles 0/1; lane 0 shows 0x01/0x11 at cycles 3/4.
  - done_o at cycle 4.
- **Bubble:** W0 at cycle 0, valid_i low at cycle 1, W1 with last_i at cycle 2 (skew).
  - Lane 2 shows 0x03 at cycle 2, 0x00 with valid 0 at cycle 3, 0x13 at cycle 4.
  - done_o at cycle 5.
- **Backpressure / mode lock:** single word with last at cycle 0. Next word presented at cycle 1 with mode_i toggled.
  - ready_o=0 cycles 1–3; next word accepted at cycle 4 with the new mode.
  - A mode_i toggle during STREAM changes no tap.
- **Clear/reset mid-drain:** clr_i at cycle 2 of a drain.
  - Next cycle: all outputs zero, IDLE, no done_o.
  - Repeat with rst_ni pulsed low asynchronously between edges: outputs zero immediately.

Source files
------------

// File: rtl/systolic_skew_buffer_if.sv
// Stream-side signal bundle for systolic_skew_buffer.
// Signal suffixes are relative to the skew buffer, which takes the slave modport.
interface systolic_skew_buffer_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LANES      = 10
);
    logic                        mode_i;
    logic                        valid_i;
    logic                        last_i;
    logic                        ready_o;
    logic [LANES*DATA_WIDTH-1:0] word_i;
    logic [LANES*DATA_WIDTH-1:0] skew_o;
    logic [LANES-1:0]            lane_valid_o;
    logic                        busy_o;
    logic                        done_o;

    modport master (
        output mode_i, valid_i, last_i, word_i,
        input  ready_o, skew_o, lane_valid_o, busy_o, done_o
    );

    modport slave (
        input  mode_i, valid_i, last_i, word_i,
        output ready_o, skew_o, lane_valid_o, busy_o, done_o
    );
endinterface

// File: rtl/systolic_skew_buffer.sv
// Per-lane skew/deskew delay stage with a burst controller that drains the
// pipeline after the last word so every burst ends with empty delay lines.
module systolic_skew_buffer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LANES      = 10
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clr_i,
    systolic_skew_buffer_if.slave bus_io
);
    localparam int unsigned CntW = $clog2(LANES);

    if (LANES < 2) begin : g_bad_lanes
        $error("systolic_skew_buffer: LANES must be >= 2");
    end

    typedef enum logic [1:0] {StIdle, StStream, StDrain} state_e;

    state_e                          state_q, state_d;
    logic [CntW-1:0]                 cnt_q, cnt_d;
    logic                            mode_q, mode_d;
    logic                            accept;
    logic                            mode_eff;
    logic [LANES*DATA_WIDTH-1:0]     inj_word;
    logic [LANES-1:0][DATA_WIDTH-1:0] lane_data;
    logic [LANES-1:0]                lane_vld;

    assign bus_io.ready_o = (state_q != StDrain);
    assign accept         = bus_io.valid_i && bus_io.ready_o;
    assign inj_word       = accept ? bus_io.word_i : '0;
    // mode_i only steers taps while idle; a burst keeps the mode it started with
    assign mode_eff       = (state_q == StIdle) ? bus_io.mode_i : mode_q;
    assign bus_io.busy_o  = (state_q != StIdle);
    assign bus_io.done_o  = (state_q == StDrain) && (cnt_q == CntW'(1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    mode_d = bus_io.mode_i;
                    if (bus_io.last_i) begin
                        state_d = StDrain;
                        cnt_d   = CntW'(LANES - 1);
                    end else begin
                        state_d = StStream;
                    end
                end
            end
            StStream: begin
                if (accept && bus_io.last_i) begin
                    state_d = StDrain;
                    cnt_d   = CntW'(LANES - 1);
                end
            end
            StDrain: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CntW'(1)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
        end else if (clr_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        localparam int unsigned SkewD = k;
        localparam int unsigned DeskD = LANES - 1 - k;
        // Line only as deep as the longer of this lane's two taps
        localparam int unsigned MaxD  = (SkewD > DeskD) ? SkewD : DeskD;

        logic [MaxD-1:0][DATA_WIDTH-1:0] line_q;
        logic [MaxD-1:0]                 vld_q;
        logic [DATA_WIDTH-1:0]           skew_tap, desk_tap;
        logic                            skew_v, desk_v;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                line_q <= '0;
                vld_q  <= '0;
            end else if (clr_i) begin
                line_q <= '0;
                vld_q  <= '0;
            end else begin
                line_q[0] <= inj_word[k*DATA_WIDTH +: DATA_WIDTH];
                vld_q[0]  <= accept;
                for (int j = 1; j < int'(MaxD); j++) begin
                    line_q[j] <= line_q[j-1];
                    vld_q[j]  <= vld_q[j-1];
                end
            end
        end

        if (SkewD == 0) begin : g_skew_pass
            assign skew_tap = inj_word[k*DATA_WIDTH +: DATA_WIDTH];
            assign skew_v   = accept;
        end else begin : g_skew_tap
            assign skew_tap = line_q[SkewD-1];
            assign skew_v   = vld_q[SkewD-1];
        end

        if (DeskD == 0) begin : g_desk_pass
            assign desk_tap = inj_word[k*DATA_WIDTH +: DATA_WIDTH];
            assign desk_v   = accept;
        end else begin : g_desk_tap
            assign desk_tap = line_q[DeskD-1];
            assign desk_v   = vld_q[DeskD-1];
        end

        assign lane_data[k] = mode_eff ? desk_tap : skew_tap;
        assign lane_vld[k]  = mode_eff ? desk_v : skew_v;
    end

    assign bus_io.skew_o       = lane_data;
    assign bus_io.lane_valid_o = lane_vld;
endmodule
